// File: rtl/mcu_dmi_pkg.sv
// -----------------------------------------------------------------------------
// mcu_dmi_pkg
// Types and constants shared by the MCU DMI uncore bridge.
//   state_e     : bridge FSM states (IDLE, REQ)
//   STATUS_ADDR_DEF : default DMI address of the bridge-local status register
//   ST_*        : bit positions inside the 32-bit status word
//   status_t    : packed view of the status word
// -----------------------------------------------------------------------------
package mcu_dmi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [6:0] STATUS_ADDR_DEF = 7'h7F;

  localparam int ST_BUSY    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_CNT_LSB = 8;

  // Field order is MSB first, so busy lands on bit 0 and the completion
  // count on bits [15:8], matching the ST_* indices above.
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  cmpl_cnt;
    logic [3:0]  rsvd_lo;
    logic        overrun;
    logic        timeout;
    logic        err;
    logic        busy;
  } status_t;

endpackage

// File: rtl/mcu_dmi_uncore_bridge.sv
// -----------------------------------------------------------------------------
// mcu_dmi_uncore_bridge
// Turns the one-cycle uncore DMI strobe from the DMI aperture mux into a held
// req/ack transaction on the uncore register bus, returns registered read
// data, aborts requests that are never acknowledged, and keeps a local sticky
// status register at STATUS_ADDR (never forwarded).
//
// Ports
//   clk, rst_l                  : clock, synchronous active-low reset
//   dmi_uncore_en/wr_en/addr/wdata : single-cycle access strobe and fields
//   dmi_uncore_rdata            : registered read data back to the DMI mux
//   uncore_req/we/addr/wdata    : request to the fabric, held until ack/timeout
//   uncore_ack/rdata/err        : one-cycle completion from the fabric
//   bridge_busy                 : high while a request is outstanding
// -----------------------------------------------------------------------------
module mcu_dmi_uncore_bridge
  import mcu_dmi_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         CNT_W          = 8,
  parameter logic [6:0] STATUS_ADDR    = STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        dmi_uncore_en,
  input  logic        dmi_uncore_wr_en,
  input  logic [6:0]  dmi_uncore_addr,
  input  logic [31:0] dmi_uncore_wdata,
  output logic [31:0] dmi_uncore_rdata,
  output logic        uncore_req,
  output logic        uncore_we,
  output logic [6:0]  uncore_addr,
  output logic [31:0] uncore_wdata,
  input  logic        uncore_ack,
  input  logic [31:0] uncore_rdata,
  input  logic        uncore_err,
  output logic        bridge_busy
);

  // Last counter value before the watchdog fires: counter starts at 0 in the
  // first REQ cycle, so req stays up for exactly TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wdog_q;
  logic [7:0]         cmpl_cnt_q;
  logic               err_q, timeout_q, overrun_q;
  status_t            status;

  // Decoded one-cycle actions
  logic start, done_ack, done_timeout, overrun_hit, status_rd, status_clr;

  // Request and busy are both pure functions of the state register, so they
  // drop on the very edge that returns the FSM to IDLE (or resets it).
  assign uncore_req  = (state_q == REQ);
  assign bridge_busy = (state_q == REQ);

  always_comb begin
    status          = '0;
    status.busy     = (state_q == REQ);
    status.err      = err_q;
    status.timeout  = timeout_q;
    status.overrun  = overrun_q;
    status.cmpl_cnt = cmpl_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    state_d      = state_q;
    start        = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    overrun_hit  = 1'b0;
    status_rd    = 1'b0;
    status_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A late ack after a timeout lands here and is simply ignored.
        if (dmi_uncore_en) begin
          if (dmi_uncore_addr == STATUS_ADDR) begin
            status_rd  = !dmi_uncore_wr_en;
            status_clr = dmi_uncore_wr_en && dmi_uncore_wdata[0];
          end else begin
            start   = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        // A new strobe while busy is dropped; the live transaction continues.
        overrun_hit = dmi_uncore_en;
        if (uncore_ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
        end else if (wdog_q == TO_LAST) begin
          done_timeout = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request fields, watchdog, read data, sticky status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      uncore_we        <= 1'b0;
      uncore_addr      <= '0;
      uncore_wdata     <= '0;
      dmi_uncore_rdata <= '0;
      wdog_q           <= '0;
      cmpl_cnt_q       <= '0;
      err_q            <= 1'b0;
      timeout_q        <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      if (start) begin
        uncore_we    <= dmi_uncore_wr_en;
        uncore_addr  <= dmi_uncore_addr;
        uncore_wdata <= dmi_uncore_wdata;
        wdog_q       <= '0;
      end else if (state_q == REQ && state_d == REQ) begin
        wdog_q <= wdog_q + CNT_W'(1);
      end

      // Fields return to zero with req so the bus is quiet between requests.
      if (state_q == REQ && state_d == IDLE) begin
        uncore_we    <= 1'b0;
        uncore_addr  <= '0;
        uncore_wdata <= '0;
      end

      if (status_rd) dmi_uncore_rdata <= status;

      if (done_ack) begin
        if (!uncore_we) dmi_uncore_rdata <= uncore_err ? 32'h0 : uncore_rdata;
        if (uncore_err) err_q <= 1'b1;
        cmpl_cnt_q <= cmpl_cnt_q + 8'd1;
      end

      if (done_timeout) begin
        timeout_q <= 1'b1;
        if (!uncore_we) dmi_uncore_rdata <= 32'h0;
      end

      if (overrun_hit) overrun_q <= 1'b1;

      // Status clear only happens in IDLE, so it never races the set terms.
      if (status_clr) begin
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcu_dmi_uncore_bridge.sv
// -----------------------------------------------------------------------------
// tb_mcu_dmi_uncore_bridge
// Directed self-checking bench for mcu_dmi_uncore_bridge (TIMEOUT_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge they were registered on.
// -----------------------------------------------------------------------------
module tb_mcu_dmi_uncore_bridge;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        dmi_uncore_en;
  logic        dmi_uncore_wr_en;
  logic [6:0]  dmi_uncore_addr;
  logic [31:0] dmi_uncore_wdata;
  logic [31:0] dmi_uncore_rdata;
  logic        uncore_req;
  logic        uncore_we;
  logic [6:0]  uncore_addr;
  logic [31:0] uncore_wdata;
  logic        uncore_ack;
  logic [31:0] uncore_rdata;
  logic        uncore_err;
  logic        bridge_busy;

  int n_checks = 0;
  int n_fails  = 0;

  mcu_dmi_uncore_bridge #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8),
    .STATUS_ADDR   (7'h7F)
  ) dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .dmi_uncore_en   (dmi_uncore_en),
    .dmi_uncore_wr_en(dmi_uncore_wr_en),
    .dmi_uncore_addr (dmi_uncore_addr),
    .dmi_uncore_wdata(dmi_uncore_wdata),
    .dmi_uncore_rdata(dmi_uncore_rdata),
    .uncore_req      (uncore_req),
    .uncore_we       (uncore_we),
    .uncore_addr     (uncore_addr),
    .uncore_wdata    (uncore_wdata),
    .uncore_ack      (uncore_ack),
    .uncore_rdata    (uncore_rdata),
    .uncore_err      (uncore_err),
    .bridge_busy     (bridge_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle DMI strobe; returns with en deasserted, one edge later.
  task automatic dmi_access(input logic wr, input logic [6:0] addr,
                            input logic [31:0] wdata);
    dmi_uncore_en    = 1'b1;
    dmi_uncore_wr_en = wr;
    dmi_uncore_addr  = addr;
    dmi_uncore_wdata = wdata;
    tick();
    dmi_uncore_en    = 1'b0;
    dmi_uncore_wr_en = 1'b0;
    dmi_uncore_wdata = '0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] expected);
    dmi_access(1'b0, 7'h7F, 32'h0);
    check(tag, dmi_uncore_rdata, expected);
  endtask

  int n;

  initial begin
    rst_l            = 1'b0;
    dmi_uncore_en    = 1'b0;
    dmi_uncore_wr_en = 1'b0;
    dmi_uncore_addr  = '0;
    dmi_uncore_wdata = '0;
    uncore_ack       = 1'b0;
    uncore_rdata     = '0;
    uncore_err       = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req",   uncore_req,       0);
    check("rst_we",    uncore_we,        0);
    check("rst_addr",  uncore_addr,      0);
    check("rst_wdata", uncore_wdata,     0);
    check("rst_rdata", dmi_uncore_rdata, 0);
    check("rst_busy",  bridge_busy,      0);
    rst_l = 1'b1;
    tick();
    check_status("rst_status", 32'h0000_0000);

    // Read, ack in the first REQ cycle: req at N+1, rdata at N+2
    dmi_access(1'b0, 7'h50, 32'h0);
    check("rd_req_n1",  uncore_req,  1);
    check("rd_busy_n1", bridge_busy, 1);
    check("rd_addr",    uncore_addr, 32'h50);
    check("rd_we",      uncore_we,   0);
    uncore_ack   = 1'b1;
    uncore_rdata = 32'hA5A5_0001;
    tick();
    uncore_ack   = 1'b0;
    uncore_rdata = '0;
    check("rd_rdata_n2", dmi_uncore_rdata, 32'hA5A5_0001);
    check("rd_req_n2",   uncore_req,       0);
    check_status("rd_status", 32'h0000_0100);

    // Write, acked in the third REQ cycle; fields stable throughout
    dmi_access(1'b1, 7'h60, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      check("wr_req",   uncore_req,   1);
      check("wr_we",    uncore_we,    1);
      check("wr_addr",  uncore_addr,  32'h60);
      check("wr_wdata", uncore_wdata, 32'h1234_5678);
      if (i == 2) uncore_ack = 1'b1;
      tick();
    end
    uncore_ack = 1'b0;
    check("wr_req_drop", uncore_req,       0);
    check("wr_rdata",    dmi_uncore_rdata, 32'h0000_0100);

    // Timeout: req stays up exactly TIMEOUT_CYCLES=4 cycles
    dmi_access(1'b0, 7'h70, 32'h0);
    n = 0;
    while (uncore_req && n < 20) begin
      n++;
      tick();
    end
    check("to_req_cycles", n, 4);
    check("to_rdata",      dmi_uncore_rdata, 32'h0);
    check("to_busy",       bridge_busy,      0);
    // TIMEOUT sticky plus two earlier completions
    check_status("to_status", 32'h0000_0204);

    // Stray ack in IDLE is ignored
    uncore_ack   = 1'b1;
    uncore_rdata = 32'hDEAD_BEEF;
    uncore_err   = 1'b1;
    tick();
    uncore_ack   = 1'b0;
    uncore_rdata = '0;
    uncore_err   = 1'b0;
    check("stray_req",   uncore_req,       0);
    check("stray_rdata", dmi_uncore_rdata, 32'h0000_0204);
    check_status("stray_status", 32'h0000_0204);

    // Read completing with error
    dmi_access(1'b0, 7'h51, 32'h0);
    uncore_ack   = 1'b1;
    uncore_err   = 1'b1;
    uncore_rdata = 32'hFFFF_FFFF;
    tick();
    uncore_ack   = 1'b0;
    uncore_err   = 1'b0;
    uncore_rdata = '0;
    check("err_rdata", dmi_uncore_rdata, 32'h0);
    check_status("err_status", 32'h0000_0306);

    // Status write with wdata[0]=1 clears sticky bits, keeps count
    dmi_access(1'b1, 7'h7F, 32'h0000_0001);
    check("clr_no_req", uncore_req, 0);
    check_status("clr_status", 32'h0000_0300);

    // Overrun: second strobe while in REQ is dropped
    dmi_access(1'b0, 7'h52, 32'h0);
    dmi_access(1'b0, 7'h52, 32'h0);
    check("ovr_req_held", uncore_req,  1);
    check("ovr_addr",     uncore_addr, 32'h52);
    uncore_ack   = 1'b1;
    uncore_rdata = 32'hCAFE_0001;
    tick();
    uncore_ack   = 1'b0;
    uncore_rdata = '0;
    check("ovr_rdata", dmi_uncore_rdata, 32'hCAFE_0001);
    check("ovr_req_drop", uncore_req, 0);
    tick();
    check("ovr_no_second_req", uncore_req, 0);
    check_status("ovr_status", 32'h0000_0408);

    // Reset in the middle of a request
    dmi_access(1'b1, 7'h61, 32'h55AA_55AA);
    check("mid_req", uncore_req, 1);
    rst_l = 1'b0;
    tick();
    check("mid_rst_req",   uncore_req,       0);
    check("mid_rst_we",    uncore_we,        0);
    check("mid_rst_addr",  uncore_addr,      0);
    check("mid_rst_wdata", uncore_wdata,     0);
    check("mid_rst_rdata", dmi_uncore_rdata, 0);
    check("mid_rst_busy",  bridge_busy,      0);
    rst_l = 1'b1;
    tick();
    check_status("mid_rst_status", 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
